uart_tx_engine: RTL
===================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter UART_CSR_ADDR, default 16'h00F1, word address of the UART CSR in combined memory.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port uart_io_reg  input  32  live UART data word from memory; bits [7:0] are the byte to send.
REQ-006 SHALL have port uart_csr_reg  input  32  live UART CSR word from memory.
REQ-007 SHALL have port wb_req  output  1  request to write the CSR back into memory.
REQ-008 SHALL have port wb_ack  input  1  write granted; memory commits wb_data at this rising edge.
REQ-009 SHALL have port wb_addr  output  16  write-back address, constant UART_CSR_ADDR.
REQ-010 SHALL have port wb_data  output  32  write-back CSR value.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 CSR bits SHALL be: bit0 START (software sets), bit1 BUSY, bit2 DONE; bits [31:3] preserved untouched.
REQ-014 States SHALL be IDLE, WB_START, START_BIT, DATA, STOP_BIT, WB_DONE.
REQ-015 IDLE: tx=1, wb_req=0; if uart_csr_reg[0]=1 at an edge, SHALL latch uart_io_reg[7:0] and uart_csr_reg, go to WB_START.
REQ-016 WB_START: wb_req=1, wb_data = latched CSR with START=0, BUSY=1, DONE=0; SHALL hold wb_req, wb_addr, wb_data stable until wb_ack=1 sampled.
REQ-017 On the edge sampling wb_ack=1 in WB_START, SHALL enter START_BIT; wb_req low in the following cycle.
REQ-018 START_BIT: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits, LSB first, each exactly CLKS_PER_BIT cycles; bit index 0..7, after bit 7 go to STOP_BIT.
REQ-020 STOP_BIT: tx=1 for exactly CLKS_PER_BIT cycles; at its last cycle SHALL capture current uart_csr_reg and enter WB_DONE.
REQ-021 WB_DONE: tx=1, wb_req=1, wb_data = captured CSR with START=0, BUSY=0, DONE=1; on wb_ack=1 go to IDLE.
REQ-022 Frame length from first tx=0 cycle to WB_DONE entry SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-023 wb_ack while wb_req=0 SHALL be ignored.
REQ-024 Changes to uart_io_reg or uart_csr_reg after latching SHALL NOT alter the byte in flight.
REQ-025 START set by software during a frame SHALL be ignored until IDLE; if still set in the captured CSR it is cleared by the WB_DONE write (one byte per START write).
REQ-026 Stalled wb_ack SHALL stall indefinitely in WB_START/WB_DONE with no timeout; tx stays 1.
REQ-027 tx, wb_req, busy SHALL be registered (glitch-free).
REQ-028 Baud counter width SHALL be $clog2(CLKS_PER_BIT); counter reloads at each bit boundary, no drift across bits.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, tx=1, wb_req=0, busy=0, wb_data=0, counters and bit index 0, latched byte 0.
REQ-030 Reset mid-frame SHALL abort the frame with no CSR write-back; on release the engine re-triggers only if CSR START=1.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum, CSR bit positions (START, BUSY, DONE) and default address constants.
REQ-032 One sub-module uart_baud_tick (CLKS_PER_BIT counter, enable in, tick out) SHALL be used; all else in uart_tx_engine.

Verification (CLKS_PER_BIT=4)
REQ-033 CSR=0x1, io=0xA5, wb_ack immediate -> write 0x2, then tx 0,1,0,1,0,0,1,0,1,1 each 4 cycles, then write 0x4.
REQ-034 CSR=0xFFFF_FF01 -> first write 0xFFFF_FF02, final write 0xFFFF_FF04 (upper bits preserved).
REQ-035 wb_ack held low 20 cycles in WB_START -> wb_req/wb_data stable, tx=1, START_BIT begins edge after ack.
REQ-036 Change io to 0x00 during DATA -> line still carries 0xA5.
REQ-037 rst_n low mid-DATA -> tx=1 and busy=0 same cycle, no wb_req; CSR START=0 on release -> stays IDLE.
REQ-038 Back-to-back: software sets START in cycle after DONE write -> next frame starts, no lost or duplicate byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_START,
        ST_START_BIT,
        ST_DATA,
        ST_STOP_BIT,
        ST_WB_DONE
    } uart_state_e;

    // CSR bit positions; bits [31:3] belong to software and pass through untouched.
    localparam int CSR_START = 0;
    localparam int CSR_BUSY  = 1;
    localparam int CSR_DONE  = 2;

    localparam int          CLKS_PER_BIT_DEFAULT  = 434;
    localparam logic [15:0] UART_CSR_ADDR_DEFAULT = 16'h00F1;

    // Build the CSR write-back word: keep software bits, clear START, set BUSY/DONE.
    function automatic logic [31:0] csr_status(input logic [31:0] csr,
                                               input logic        busy_bit,
                                               input logic        done_bit);
        logic [31:0] r;
        r            = csr;
        r[CSR_START] = 1'b0;
        r[CSR_BUSY]  = busy_bit;
        r[CSR_DONE]  = done_bit;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// CSR write-back handshake bundle between the engine and combined memory.
interface uart_tx_engine_if;
    logic        wb_req;
    logic        wb_ack;
    logic [15:0] wb_addr;
    logic [31:0] wb_data;

    modport master (output wb_req, output wb_addr, output wb_data, input wb_ack);
    modport slave  (input wb_req, input wb_addr, input wb_data, output wb_ack);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: ticks on the last cycle of every CLKS_PER_BIT window while enabled.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload at each bit boundary so every bit is exactly CLKS_PER_BIT cycles.
    always_comb begin
        cnt_d = '0;
        if (en && cnt_q != LAST)
            cnt_d = cnt_q + 1'b1;
    end

    assign tick = en && (cnt_q == LAST);

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_engine.sv
// Memory-mapped UART transmitter: software sets CSR.START, engine reports
// BUSY via a CSR write-back, shifts the byte out 8N1, then writes DONE.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
    parameter logic [15:0] UART_CSR_ADDR = UART_CSR_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] uart_io_reg,
    input  logic [31:0] uart_csr_reg,
    output logic        wb_req,
    input  logic        wb_ack,
    output logic [15:0] wb_addr,
    output logic [31:0] wb_data,
    output logic        tx,
    output logic        busy
);
    uart_state_e state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        tx_q, tx_d;
    logic        wb_req_q, wb_req_d;
    logic        busy_q, busy_d;
    logic        baud_en, tick;

    assign baud_en = (state_q == ST_START_BIT) || (state_q == ST_DATA) ||
                     (state_q == ST_STOP_BIT);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (baud_en),
        .tick  (tick)
    );

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bit_idx_d = bit_idx_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_IDLE: if (uart_csr_reg[CSR_START]) begin
                byte_d    = uart_io_reg[7:0];
                wb_data_d = csr_status(uart_csr_reg, 1'b1, 1'b0);
                state_d   = ST_WB_START;
            end
            ST_WB_START: if (wb_ack) begin
                bit_idx_d = '0;
                state_d   = ST_START_BIT;
            end
            ST_START_BIT: if (tick) state_d = ST_DATA;
            ST_DATA: if (tick) begin
                if (bit_idx_q == 3'd7) state_d = ST_STOP_BIT;
                else                   bit_idx_d = bit_idx_q + 3'd1;
            end
            ST_STOP_BIT: if (tick) begin
                wb_data_d = csr_status(uart_csr_reg, 1'b0, 1'b1);
                state_d   = ST_WB_DONE;
            end
            ST_WB_DONE: if (wb_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        tx_d = 1'b1;
        if (state_d == ST_START_BIT) tx_d = 1'b0;
        else if (state_d == ST_DATA) tx_d = byte_d[bit_idx_d];
        wb_req_d = (state_d == ST_WB_START) || (state_d == ST_WB_DONE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any frame without write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            bit_idx_q <= '0;
            wb_data_q <= '0;
            tx_q      <= 1'b1;
            wb_req_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            bit_idx_q <= bit_idx_d;
            wb_data_q <= wb_data_d;
            tx_q      <= tx_d;
            wb_req_q  <= wb_req_d;
            busy_q    <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign wb_req  = wb_req_q;
    assign busy    = busy_q;
    assign wb_data = wb_data_q;
    assign wb_addr = UART_CSR_ADDR;
endmodule
